// File: rtl/rv_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_div_pkg
// Description : Shared types and constants for the RV32M iterative divider.
//               Op encoding follows funct3[1:0] of DIV/DIVU/REM/REMU:
//               bit 0 set means unsigned, bit 1 set means remainder.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   localparam int DIV_DATA_WIDTH = 32;
   localparam int DIV_CNT_WIDTH  = 6;

   localparam logic [DIV_DATA_WIDTH-1:0] MIN_INT  = {1'b1, {(DIV_DATA_WIDTH-1){1'b0}}};
   localparam logic [DIV_DATA_WIDTH-1:0] ALL_ONES = {DIV_DATA_WIDTH{1'b1}};

endpackage
`default_nettype wire

// File: rtl/rv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : rv_div_step
// Description : One combinational restoring-division iteration. Shifts the
//               next dividend bit (MSB of the quotient register) into the
//               partial remainder, trial-subtracts the divisor and keeps the
//               difference only if it is non-negative. The quotient register
//               shifts left, taking the new quotient bit in its LSB.
// Ports       : prem      in  DATA_WIDTH+1  current partial remainder
//               quo       in  DATA_WIDTH    dividend bits / quotient so far
//               dvsr      in  DATA_WIDTH    divisor magnitude
//               prem_nxt  out DATA_WIDTH+1  next partial remainder
//               quo_nxt   out DATA_WIDTH    next quotient register
// Revision    : 1.0 - initial release
// ============================================================================
module rv_div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH:0]   prem,
   input  logic [DATA_WIDTH-1:0] quo,
   input  logic [DATA_WIDTH-1:0] dvsr,
   output logic [DATA_WIDTH:0]   prem_nxt,
   output logic [DATA_WIDTH-1:0] quo_nxt
);

   // One guard bit above the partial remainder so the trial difference
   // carries an unambiguous sign bit.
   logic [DATA_WIDTH+1:0] w_shift;
   logic [DATA_WIDTH+1:0] w_diff;

   assign w_shift = {prem, quo[DATA_WIDTH-1]};
   assign w_diff  = w_shift - {2'b00, dvsr};

   always_comb begin
      prem_nxt = w_shift[DATA_WIDTH:0];
      quo_nxt  = {quo[DATA_WIDTH-2:0], 1'b0};
      if (!w_diff[DATA_WIDTH+1]) begin
         prem_nxt = w_diff[DATA_WIDTH:0];
         quo_nxt  = {quo[DATA_WIDTH-2:0], 1'b1};
      end
   end

endmodule
`default_nettype wire

// File: rtl/rv_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv_div_unit
// Description : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/
//               REMU. Divide-by-zero and signed overflow are resolved at
//               accept time (one-cycle latency); all other operations take
//               DATA_WIDTH iteration cycles. Result is registered and held
//               until consumed.
// Ports       : clk          in  1   clock, rising edge
//               rst_n        in  1   asynchronous active-low reset
//               flush        in  1   kill in-flight op, highest priority
//               start_valid  in  1   operands/op valid
//               start_ready  out 1   unit idle, can accept
//               op           in  2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//               dividend     in  W   rs1
//               divisor      in  W   rs2
//               res_valid    out 1   result valid
//               res_ready    in  1   writeback consumes result
//               result       out W   quotient or remainder
//               busy         out 1   unit not idle
// Revision    : 1.0 - initial release
// ============================================================================
module rv_div_unit
   import rv_div_pkg::*;
#(
   parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  busy
);

   // Width-matched copies of the package constants.
   localparam logic [DATA_WIDTH-1:0]    MIN_INT_W  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0]    ALL_ONES_W = {DATA_WIDTH{1'b1}};
   localparam logic [DIV_CNT_WIDTH-1:0] LAST_STEP  = DIV_CNT_WIDTH'(DATA_WIDTH - 1);

   div_state_e                r_state;
   div_state_e                w_state_nxt;
   div_op_e                   w_op_in;
   div_op_e                   r_op;
   logic                      r_neg_q;
   logic                      r_neg_r;
   logic [DATA_WIDTH:0]       r_prem;
   logic [DATA_WIDTH-1:0]     r_quo;
   logic [DATA_WIDTH-1:0]     r_dvsr;
   logic [DIV_CNT_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0]     r_result;

   logic                      w_signed;
   logic                      w_is_rem;
   logic                      w_accept;
   logic                      w_div_zero;
   logic                      w_overflow;
   logic                      w_special;
   logic [DATA_WIDTH-1:0]     w_special_res;
   logic [DATA_WIDTH-1:0]     w_dvd_mag;
   logic [DATA_WIDTH-1:0]     w_dvs_mag;
   logic                      w_last;
   logic [DATA_WIDTH:0]       w_prem_nxt;
   logic [DATA_WIDTH-1:0]     w_quo_nxt;
   logic [DATA_WIDTH-1:0]     w_q_fix;
   logic [DATA_WIDTH-1:0]     w_r_fix;
   logic [DATA_WIDTH-1:0]     w_final;

   // ------------------------------------------------------------------------
   // Status outputs, decoded from state
   // ------------------------------------------------------------------------
   assign start_ready = (r_state == IDLE);
   assign res_valid   = (r_state == DONE);
   assign busy        = (r_state != IDLE);
   assign result      = r_result;

   // ------------------------------------------------------------------------
   // Accept-time decode
   // ------------------------------------------------------------------------
   assign w_op_in    = div_op_e'(op);
   assign w_signed   = ~op[0];
   assign w_is_rem   = op[1];
   assign w_accept   = start_valid & start_ready & ~flush;
   assign w_div_zero = (divisor == '0);
   assign w_overflow = w_signed & (dividend == MIN_INT_W) & (divisor == ALL_ONES_W);
   assign w_special  = w_div_zero | w_overflow;

   always_comb begin
      w_special_res = '0;
      if (w_div_zero) begin
         w_special_res = w_is_rem ? dividend : ALL_ONES_W;
      end else begin
         w_special_res = w_is_rem ? '0 : MIN_INT_W;
      end
   end

   // MIN_INT negates to itself, which is its correct unsigned magnitude.
   assign w_dvd_mag = (w_signed & dividend[DATA_WIDTH-1]) ? -dividend : dividend;
   assign w_dvs_mag = (w_signed & divisor[DATA_WIDTH-1])  ? -divisor  : divisor;

   // ------------------------------------------------------------------------
   // Iteration datapath and sign fixup
   // ------------------------------------------------------------------------
   rv_div_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .prem     (r_prem),
      .quo      (r_quo),
      .dvsr     (r_dvsr),
      .prem_nxt (w_prem_nxt),
      .quo_nxt  (w_quo_nxt)
   );

   assign w_last  = (r_state == CALC) && (r_cnt == LAST_STEP);
   assign w_q_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
   assign w_r_fix = r_neg_r ? -w_prem_nxt[DATA_WIDTH-1:0] : w_prem_nxt[DATA_WIDTH-1:0];
   assign w_final = ((r_op == REM) || (r_op == REMU)) ? w_r_fix : w_q_fix;

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: if (start_valid) w_state_nxt = w_special ? DONE : CALC;
            CALC: if (r_cnt == LAST_STEP) w_state_nxt = DONE;
            DONE: if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Operand, iteration and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= DIV;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_prem   <= '0;
         r_quo    <= '0;
         r_dvsr   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op    <= w_op_in;
         r_neg_q <= (w_op_in == DIV) & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
         r_neg_r <= (w_op_in == REM) & dividend[DATA_WIDTH-1];
         r_prem  <= '0;
         r_quo   <= w_dvd_mag;
         r_dvsr  <= w_dvs_mag;
         r_cnt   <= '0;
         if (w_special) begin
            r_result <= w_special_res;
         end
      end else if ((r_state == CALC) && !flush) begin
         // A flush on the final step must leave the old result untouched.
         r_prem <= w_prem_nxt;
         r_quo  <= w_quo_nxt;
         r_cnt  <= r_cnt + DIV_CNT_WIDTH'(1);
         if (w_last) begin
            r_result <= w_final;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rv_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_div_unit
// Description : Self-checking bench for rv_div_unit. Directed RV32M corner
//               vectors, backpressure, flush and mid-operation reset, then
//               randomized operations checked against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rv_div_unit #(.DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op          (op),
      .dividend    (dividend),
      .divisor     (divisor),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics expressed with native SV arithmetic.
   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (o)
         2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
         2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return 32'd1;
      if (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 32'd1;
      return 32'd33;
   endfunction

   // Wait (bounded) for res_valid; called at a negedge.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (res_valid) break;
      end
   endtask

   // Full transaction; entered and left at a negedge.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
      int lat;
      bit sr_low;
      op = o; dividend = a; divisor = b; start_valid = 1'b1;
      @(posedge clk); #1;
      // Operands need not stay stable after accept.
      start_valid = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
      lat = 0; sr_low = 1'b1;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (res_valid) break;
         if (start_ready) sr_low = 1'b0;
      end
      check({tag, ".lat"}, 32'(lat), ref_lat(o, a, b));
      check({tag, ".res"}, result, exp_res);
      check({tag, ".rdy_low"}, 32'(sr_low), 32'd1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      check({tag, ".idle"}, 32'({start_ready, res_valid}), 32'd2);
   endtask

   initial begin : main
      int          lat;
      bit          seen;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      // Reset
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.start_ready", 32'(start_ready), 32'd1);
      check("rst.res_valid", 32'(res_valid), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.result", result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors
      do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
      do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
      do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      do_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
      do_op("div_m8_m2",  2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4);
      do_op("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
      do_op("remu_5_0",   2'b11, 32'd5, 32'd0, 32'd5);
      do_op("divu_big_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      do_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      // Backpressure: hold res_ready low for 10 cycles in DONE
      op = 2'b01; dividend = 32'd1000; divisor = 32'd7; start_valid = 1'b1;
      @(posedge clk); #1 start_valid = 1'b0;
      wait_valid(lat);
      check("bp.lat", 32'(lat), 32'd33);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp.hold_valid", 32'(res_valid), 32'd1);
         check("bp.hold_result", result, 32'd142);
      end
      // Handshake with the next start already presented
      res_ready = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3; start_valid = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      check("bp.no_same_cycle", 32'({start_ready, busy}), 32'd2);
      @(posedge clk); #1 start_valid = 1'b0;
      @(negedge clk);
      check("bp.next_accepted", 32'({start_ready, busy}), 32'd1);
      wait_valid(lat);
      check("bp.next_lat", 32'(lat), 32'd32);
      check("bp.next_res", result, 32'd3);
      res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);

      // Flush in CALC
      op = 2'b01; dividend = 32'h1234_5678; divisor = 32'd3; start_valid = 1'b1;
      @(posedge clk); #1 start_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("fl.busy", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("fl.start_ready", 32'(start_ready), 32'd1);
      check("fl.result_kept", result, 32'd3);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      check("fl.no_valid", 32'(seen), 32'd0);
      // Start presented together with flush is dropped
      op = 2'b01; dividend = 32'd50; divisor = 32'd5; start_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1 start_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("fl.start_dropped", 32'(busy), 32'd0);

      // Reset mid-CALC
      op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start_valid = 1'b1;
      @(posedge clk); #1 start_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mr.result", result, 32'd0);
      check("mr.status", 32'({start_ready, res_valid, busy}), 32'd4);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op("mr.fresh", 2'b01, 32'd9, 32'd3, 32'd3);

      // Randomized operations vs. arithmetic model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         case ($urandom_range(0, 5))
            0:       ra = 32'h8000_0000;
            1:       ra = $urandom_range(0, 20);
            2:       ra = -($urandom_range(0, 20));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 20);
            3:       rb = -($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         do_op("rand", ro, ra, rb, ref_div(ro, ra, rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
